soc_peripheral_arbiter: RTL and testbench

SOC_PERIPHERAL_ARBITER -- requirements
Module: soc_peripheral_arbiter

---
 rtl/soc_peripheral_arbiter_if.sv | 24 ++
 rtl/soc_peripheral_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_soc_peripheral_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/soc_peripheral_arbiter_if.sv
// rtl/soc_peripheral_arbiter_if.sv - SoC memory bus between a bus master and the peripheral arbiter
interface SoC_MemBus;
  logic        req;
  logic [31:0] addr;
  logic        write_en;
  logic [3:0]  byte_en;
  logic [31:0] write_data;
  logic        valid;
  logic [31:0] read_data_drv;
  wire  [31:0] read_data;

  // Read data only carries a value while a response is being presented.
  assign read_data = valid ? read_data_drv : 32'bz;

  modport Slave (
    input  req, addr, write_en, byte_en, write_data,
    output valid, read_data_drv
  );

  modport Master (
    output req, addr, write_en, byte_en, write_data,
    input  valid, read_data
  );
endinterface

// File: rtl/soc_peripheral_arbiter.sv
// rtl/soc_peripheral_arbiter.sv - decodes SoC bus accesses onto N_CH peripheral channels
// Optional access timeout enabled by defining SOC_PERIPH_TIMEOUT_EN.
module soc_peripheral_arbiter #(
  parameter int                  N_CH        = 4,
  parameter logic [N_CH*32-1:0]  CH_BASE     = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [N_CH*32-1:0]  CH_MASK     = {4{32'hFFFF_F000}},
  parameter int                  MIN_LATENCY = 1,
  parameter int                  TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                res_n,
  SoC_MemBus.Slave            bus,
  output logic [N_CH-1:0]     ch_sel,
  output logic [31:0]         ch_addr,
  output logic [31:0]         ch_write_data,
  output logic                ch_we,
  input  logic [N_CH*32-1:0]  ch_read_data,
  input  logic [N_CH*32-1:0]  ch_unchanged,
  input  logic [N_CH-1:0]     ch_ready
);

  localparam int          CW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [4:0]  LAT_REQ = 5'(MIN_LATENCY);
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t          state;
  logic [3:0]      lat_cnt;
  logic [31:0]     hold;
  logic [31:0]     lat_addr;
  logic            lat_we;
  logic [3:0]      lat_be;
  logic [31:0]     lat_wdata;
  logic [CW-1:0]   lat_ch;
  logic [N_CH-1:0] sel_r;
  logic            we_r;
  logic            valid_r;

  logic            dec_hit;
  logic [CW-1:0]   dec_ch;
  logic [N_CH-1:0] dec_onehot;
  logic            stable;
  logic            lat_met;
  logic            cond;
  logic [31:0]     sel_rdata;
  logic [31:0]     sel_unch;
  logic [31:0]     sel_mask;

  // Descending scan so the lowest-index matching window is the one kept.
  always_comb begin
    dec_hit    = 1'b0;
    dec_ch     = '0;
    dec_onehot = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if ((bus.addr & CH_MASK[i*32 +: 32]) == CH_BASE[i*32 +: 32]) begin
        dec_hit       = 1'b1;
        dec_ch        = CW'(i);
        dec_onehot    = '0;
        dec_onehot[i] = 1'b1;
      end
    end
  end

  assign stable    = bus.req && (bus.addr == lat_addr) && (bus.write_en == lat_we);
  assign sel_rdata = ch_read_data[32*lat_ch +: 32];
  assign sel_unch  = ch_unchanged[32*lat_ch +: 32];
  assign sel_mask  = CH_MASK[32*lat_ch +: 32];
  assign lat_met   = ({1'b0, lat_cnt} + 5'd1) >= LAT_REQ;
  assign cond      = lat_met && ch_ready[lat_ch];

`ifdef SOC_PERIPH_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^TMO_LIM;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      hold      <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
      lat_ch    <= '0;
      sel_r     <= '0;
      we_r      <= 1'b0;
      valid_r   <= 1'b0;
`ifdef SOC_PERIPH_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          valid_r <= 1'b0;
          we_r    <= 1'b0;
          if (bus.req) begin
            lat_addr  <= bus.addr;
            lat_we    <= bus.write_en;
            lat_be    <= bus.byte_en;
            lat_wdata <= bus.write_data;
            lat_ch    <= dec_ch;
            lat_cnt   <= '0;
`ifdef SOC_PERIPH_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            if (dec_hit) begin
              state <= ACCESS;
              sel_r <= dec_onehot;
            end else begin
              state <= FAULT;
              hold  <= '0;
            end
          end
        end

        ACCESS: begin
          if (!stable) begin
            state <= IDLE;
            sel_r <= '0;
          end else begin
            if (lat_cnt != 4'hF) lat_cnt <= lat_cnt + 4'd1;
            if (cond) begin
              if (lat_we) begin
                state <= WRITE;
                we_r  <= 1'b1;
                hold  <= '0;
              end else begin
                state <= DONE;
                hold  <= sel_rdata;
              end
            end
`ifdef SOC_PERIPH_TIMEOUT_EN
            else if (tmo_cnt == TMO_LIM) begin
              state <= FAULT;
              sel_r <= '0;
              hold  <= 32'hDEAD_BEEF;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
`endif
          end
        end

        WRITE: begin
          we_r <= 1'b0;
          if (!stable) begin
            state <= IDLE;
            sel_r <= '0;
          end else begin
            state <= DONE;
          end
        end

        // The response is presented one cycle after entry and held while the request is stable.
        DONE, FAULT: begin
          if (!stable) begin
            state   <= IDLE;
            sel_r   <= '0;
            valid_r <= 1'b0;
          end else begin
            valid_r <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          sel_r   <= '0;
          we_r    <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ch_write_data = '0;
    for (int b = 0; b < 4; b++) begin
      ch_write_data[8*b +: 8] = lat_be[b] ? lat_wdata[8*b +: 8] : sel_unch[8*b +: 8];
    end
  end

  assign ch_sel            = sel_r;
  assign ch_addr           = lat_addr & ~sel_mask;
  assign ch_we             = we_r && stable;
  assign bus.valid         = valid_r && stable;
  assign bus.read_data_drv = hold;

endmodule

// File: tb/tb_soc_peripheral_arbiter.sv
// tb/tb_soc_peripheral_arbiter.sv - vector table, corner sequences and randomized model checks for the arbiter
module tb_soc_peripheral_arbiter;

  localparam int MIN_LAT = 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    int          vedge;
  } txn_t;

  logic         clk = 1'b0;
  logic         res_n;
  logic [3:0]   ch_sel;
  logic [31:0]  ch_addr;
  logic [31:0]  ch_write_data;
  logic         ch_we;
  logic [127:0] ch_read_data;
  logic [127:0] ch_unchanged;
  logic [3:0]   ch_ready;
  logic [31:0]  rd_word   [4];
  logic [31:0]  unch_word [4];

  int n_pass  = 0;
  int n_total = 0;

  SoC_MemBus bus_if ();

  soc_peripheral_arbiter dut (
    .clk           (clk),
    .res_n         (res_n),
    .bus           (bus_if),
    .ch_sel        (ch_sel),
    .ch_addr       (ch_addr),
    .ch_write_data (ch_write_data),
    .ch_we         (ch_we),
    .ch_read_data  (ch_read_data),
    .ch_unchanged  (ch_unchanged),
    .ch_ready      (ch_ready)
  );

  always #5 clk = ~clk;

  assign ch_read_data = {rd_word[3], rd_word[2], rd_word[1], rd_word[0]};
  assign ch_unchanged = {unch_word[3], unch_word[2], unch_word[1], unch_word[0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  // Windows are 4 KiB each starting at 0; anything at or above 0x4000 is unmapped.
  function automatic txn_t model(input logic [31:0] a, input logic w, input logic [3:0] be,
                                 input logic [31:0] wd, input int d);
    txn_t t;
    int   hit;
    int   k;
    t.addr = a; t.we = w; t.be = be; t.wdata = wd; t.delay = d;
    t.exp_sel = 4'h0; t.exp_addr = 32'h0; t.exp_rdata = 32'h0; t.exp_wdata = 32'h0;
    hit = (a < 32'h4000) ? int'(a / 32'h1000) : -1;
    if (hit < 0) begin
      t.vedge = 2;
    end else begin
      k = (d > MIN_LAT - 1) ? d : MIN_LAT - 1;
      t.exp_sel   = 4'(1 << hit);
      t.exp_addr  = a % 32'h1000;
      t.exp_rdata = w ? 32'h0 : rd_word[hit];
      for (int b = 0; b < 4; b++)
        t.exp_wdata[8*b +: 8] = be[b] ? wd[8*b +: 8] : unch_word[hit][8*b +: 8];
      t.vedge = w ? 4 + k : 3 + k;
    end
    return t;
  endfunction

  // Called right after a negedge; returns right after a negedge with the block idle.
  task automatic run_txn(input txn_t t);
    bit mapped;
    mapped = (t.exp_sel != 4'h0);
    bus_if.req        = 1'b1;
    bus_if.addr       = t.addr;
    bus_if.write_en   = t.we;
    bus_if.byte_en    = t.be;
    bus_if.write_data = t.wdata;
    ch_ready          = (t.delay == 0) ? 4'hF : 4'h0;
    for (int n = 1; n <= t.vedge + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      ch_ready = (n - 1 >= t.delay) ? 4'hF : 4'h0;
      chk("sel", 32'(ch_sel), 32'(t.exp_sel));
      chk("we", 32'(ch_we), 32'(mapped && t.we && n == t.vedge - 2));
      chk("valid", 32'(bus_if.valid), 32'(n >= t.vedge));
      if (n >= t.vedge) chk("rdata", bus_if.read_data, t.exp_rdata);
      if (mapped && t.we && n == t.vedge - 2) begin
        chk("wdata", ch_write_data, t.exp_wdata);
        chk("waddr", ch_addr, t.exp_addr);
      end
      if (mapped && !t.we && n == 1) chk("raddr", ch_addr, t.exp_addr);
    end
    bus_if.req = 1'b0;
    #1;
    chk("valid_drop", 32'(bus_if.valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("sel_idle", 32'(ch_sel), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    txn_t vec [8];
    txn_t rt;
    int   r;

    rd_word   = '{32'h0BAD_0000, 32'h1111_1111, 32'hA5A5_0001, 32'h3333_CAFE};
    unch_word = '{32'h0102_0304, 32'hAABB_CCDD, 32'h5566_7788, 32'h99AA_BBCC};

    vec[0] = '{32'h0000_2010, 1'b0, 4'hF, 32'h0,         0,  4'b0100, 32'h10,  32'hA5A5_0001, 32'h0,         3};
    vec[1] = '{32'h0000_1004, 1'b1, 4'h3, 32'h1122_3344, 0,  4'b0010, 32'h4,   32'h0,         32'hAABB_3344, 4};
    vec[2] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,         10, 4'b0001, 32'h0,   32'h0BAD_0000, 32'h0,         13};
    vec[3] = '{32'h0001_0000, 1'b0, 4'hF, 32'h0,         0,  4'b0000, 32'h0,   32'h0,         32'h0,         2};
    vec[4] = '{32'h0000_3FFC, 1'b1, 4'hC, 32'hDEAD_BEEF, 2,  4'b1000, 32'hFFC, 32'h0,         32'hDEAD_BBCC, 6};
    vec[5] = '{32'h0000_0FFF, 1'b1, 4'h0, 32'h1234_5678, 0,  4'b0001, 32'hFFF, 32'h0,         32'h0102_0304, 4};
    vec[6] = '{32'h0000_3000, 1'b0, 4'hF, 32'h0,         3,  4'b1000, 32'h0,   32'h3333_CAFE, 32'h0,         6};
    vec[7] = '{32'h0002_0000, 1'b1, 4'hF, 32'hCAFE_F00D, 0,  4'b0000, 32'h0,   32'h0,         32'h0,         2};

    res_n = 1'b0;
    bus_if.req = 1'b0; bus_if.addr = 32'h0; bus_if.write_en = 1'b0;
    bus_if.byte_en = 4'h0; bus_if.write_data = 32'h0;
    ch_ready = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(ch_sel), 32'h0);
    chk("rst_we", 32'(ch_we), 32'h0);
    chk("rst_valid", 32'(bus_if.valid), 32'h0);
    chk("rst_addr", ch_addr, 32'h0);
    res_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vec[i]);

    // Address moves from channel 3 to channel 0 while the access is stalled.
    bus_if.req = 1'b1; bus_if.addr = 32'h0000_3000; bus_if.write_en = 1'b0; ch_ready = 4'h0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("chg_sel3", 32'(ch_sel), 32'h8);
    bus_if.addr = 32'h0000_0000; ch_ready = 4'hF;
    #1;
    chk("chg_valid0", 32'(bus_if.valid), 32'h0);
    chk("chg_we0", 32'(ch_we), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("chg_idle_sel", 32'(ch_sel), 32'h0);
    chk("chg_valid1", 32'(bus_if.valid), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("chg_sel0", 32'(ch_sel), 32'h1);
    @(posedge clk); @(negedge clk);
    chk("chg_valid2", 32'(bus_if.valid), 32'h0);
    chk("chg_we2", 32'(ch_we), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("chg_valid3", 32'(bus_if.valid), 32'h1);
    chk("chg_rdata", bus_if.read_data, 32'h0BAD_0000);
    bus_if.addr = 32'h0000_0004;
    #1;
    chk("chg_valid_comb", 32'(bus_if.valid), 32'h0);
    bus_if.req = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end

    // Reset pulse immediately after the write strobe cycle begins.
    bus_if.req = 1'b1; bus_if.addr = 32'h0000_1004; bus_if.write_en = 1'b1;
    bus_if.byte_en = 4'hF; bus_if.write_data = 32'h5555_AAAA; ch_ready = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1 res_n = 1'b0;
    #1;
    chk("rstw_we", 32'(ch_we), 32'h0);
    chk("rstw_valid", 32'(bus_if.valid), 32'h0);
    chk("rstw_sel", 32'(ch_sel), 32'h0);
    chk("rstw_addr", ch_addr, 32'h0);
    @(negedge clk);
    chk("rstw_we_hold", 32'(ch_we), 32'h0);
    bus_if.req = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    run_txn(vec[0]);

`ifdef SOC_PERIPH_TIMEOUT_EN
    begin
      int waited = 0;
      bus_if.req = 1'b1; bus_if.addr = 32'h0; bus_if.write_en = 1'b0; ch_ready = 4'h0;
      while (!bus_if.valid && waited < 400) begin
        @(posedge clk); @(negedge clk);
        waited++;
      end
      chk("tmo_valid", 32'(bus_if.valid), 32'h1);
      chk("tmo_rdata", bus_if.read_data, 32'hDEAD_BEEF);
      chk("tmo_sel", 32'(ch_sel), 32'h0);
      chk("tmo_late", 32'(waited >= 255), 32'h1);
      bus_if.req = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
    end
`endif

    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < 4; c++) begin
        rd_word[c]   = $urandom;
        unch_word[c] = $urandom;
      end
      r = int'($urandom_range(0, 4));
      rt = model((r < 4) ? ((32'(r) << 12) | ($urandom & 32'hFFF)) : ($urandom | 32'h0001_0000),
                 1'($urandom_range(0, 1)), 4'($urandom), $urandom, int'($urandom_range(0, 4)));
      run_txn(rt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
